// File: rtl/calc_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the calculator
// sequencer and its ALU.
package calc_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDI = 3'd5;
  localparam logic [2:0] OP_MOV = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU: result, carry/borrow, zero, and whether the opcode
// is allowed to touch the flags.
module calc_alu
  import calc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] res,
  output logic              c,
  output logic              z,
  output logic              upd_flags
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum       = '0;
    res       = '0;
    c         = 1'b0;
    upd_flags = 1'b1;
    case (op)
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        res = sum[DATA_W-1:0];
        c   = sum[DATA_W];
      end
      OP_SUB: begin
        res = a - b;
        c   = (a < b);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_LDI: begin
        res       = imm;
        upd_flags = 1'b0;
      end
      OP_MOV: res = a;
      default: upd_flags = 1'b0;
    endcase
  end

  assign z = (res == '0);

endmodule

// File: rtl/calc_sequencer.sv
// Four-phase controller for the 16x8 register file: fetch operands, execute,
// write back on the falling edge of the WRITE cycle.
//
//   state   | meaning
//   S_IDLE  | ready for an instruction
//   S_READ  | read addresses driven, operands latched at next edge
//   S_EXEC  | ALU evaluates, result/flags latched at next edge
//   S_WRITE | rf_we/done asserted, register file commits on falling edge
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              nclk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_ra,
  input  logic [ADDR_W-1:0] instr_rb,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [ADDR_W-1:0] rf_addr_b,
  output logic [ADDR_W-1:0] rf_addr_d,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_out_a,
  input  logic [DATA_W-1:0] rf_out_b,
  output logic [DATA_W-1:0] result,
  output logic              flag_c,
  output logic              flag_z,
  output logic              done,
  output logic              busy
);

  state_t            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q, ra_q, rb_q;
  logic [DATA_W-1:0] imm_q, op_a, op_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_z, alu_upd;

  calc_alu #(.DATA_W(DATA_W)) u_alu (
    .op        (op_q),
    .a         (op_a),
    .b         (op_b),
    .imm       (imm_q),
    .res       (alu_res),
    .c         (alu_c),
    .z         (alu_z),
    .upd_flags (alu_upd)
  );

  // Strobes are flops so rf_we cannot glitch around the falling-edge write.
  always_ff @(posedge nclk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      imm_q       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      result      <= '0;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      rf_we       <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      instr_ready <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q        <= instr_op;
            rd_q        <= instr_rd;
            ra_q        <= instr_ra;
            rb_q        <= instr_rb;
            imm_q       <= instr_imm;
            busy        <= 1'b1;
            instr_ready <= 1'b0;
            state       <= S_READ;
          end
        end
        S_READ: begin
          op_a  <= rf_out_a;
          op_b  <= rf_out_b;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (op_q != OP_NOP) result <= alu_res;
          if (alu_upd) begin
            flag_c <= alu_c;
            flag_z <= alu_z;
          end
          rf_we <= (op_q != OP_NOP);
          done  <= 1'b1;
          state <= S_WRITE;
        end
        S_WRITE: begin
          rf_we       <= 1'b0;
          done        <= 1'b0;
          busy        <= 1'b0;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rf_addr_a  = ra_q;
  assign rf_addr_b  = rb_q;
  assign rf_addr_d  = rd_q;
  assign rf_data_in = result;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: register file model on the falling edge, table of
// directed instructions, hand-written multi-cycle cases and random instructions.
module tb_calc_sequencer;

  logic       nclk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [3:0] instr_rd, instr_ra, instr_rb;
  logic [7:0] instr_imm;
  logic [3:0] rf_addr_a, rf_addr_b, rf_addr_d;
  logic [7:0] rf_data_in, rf_out_a, rf_out_b, result;
  logic       rf_we, flag_c, flag_z, done, busy;

  logic [7:0] rf [16];
  logic       load_rf;

  logic [7:0] mdl_regs [16];
  logic [7:0] mdl_res;
  logic       mdl_c, mdl_z;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] op;
    logic [3:0] rd, ra, rb;
    logic [7:0] imm, val;
    logic       c, z;
  } vec_t;

  vec_t tbl [9];

  always #5 nclk = ~nclk;

  calc_sequencer dut (
    .nclk        (nclk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_ra    (instr_ra),
    .instr_rb    (instr_rb),
    .instr_imm   (instr_imm),
    .rf_addr_a   (rf_addr_a),
    .rf_addr_b   (rf_addr_b),
    .rf_addr_d   (rf_addr_d),
    .rf_data_in  (rf_data_in),
    .rf_we       (rf_we),
    .rf_out_a    (rf_out_a),
    .rf_out_b    (rf_out_b),
    .result      (result),
    .flag_c      (flag_c),
    .flag_z      (flag_z),
    .done        (done),
    .busy        (busy)
  );

  always @(negedge nclk) begin
    if (load_rf) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'(i);
    end else if (rf_we) begin
      rf[rf_addr_d] <= rf_data_in;
    end
  end

  assign rf_out_a = rf[rf_addr_a];
  assign rf_out_b = rf[rf_addr_b];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Architectural effect of one instruction, from the opcode definitions.
  task automatic model_exec(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] ra,
                            input logic [3:0] rb, input logic [7:0] imm);
    int a, b, r;
    bit c, wr, fl;
    a = int'(mdl_regs[ra]);
    b = int'(mdl_regs[rb]);
    r = 0; c = 0; wr = 1; fl = 1;
    case (op)
      3'd0: begin r = a + b; c = (r > 255); end
      3'd1: begin c = (a < b); r = a - b + 256; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = int'(imm); fl = 0; end
      3'd6: r = a;
      default: begin wr = 0; fl = 0; end
    endcase
    r = r % 256;
    if (wr) begin
      mdl_res      = 8'(r);
      mdl_regs[rd] = 8'(r);
    end
    if (fl) begin
      mdl_c = c;
      mdl_z = (r == 0);
    end
  endtask

  task automatic check_regfile(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++) if (rf[i] !== mdl_regs[i]) bad++;
    check(name, bad, 0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [7:0] imm);
    int lat, n_we, t;
    lat = -1; n_we = 0; t = 0;
    @(negedge nclk);
    instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_imm = imm;
    instr_valid = 1'b1;
    while (!instr_ready && t < 20) begin
      @(negedge nclk);
      t++;
    end
    check("ready_wait", int'(instr_ready), 1);
    model_exec(op, rd, ra, rb, imm);
    @(posedge nclk);
    #1 instr_valid = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    for (int cyc = 1; cyc <= 8 && lat < 0; cyc++) begin
      @(negedge nclk);
      if (rf_we) begin
        n_we++;
        check("wr_addr", int'(rf_addr_d), int'(rd));
        check("wr_data", int'(rf_data_in), int'(mdl_res));
      end
      if (done) lat = cyc;
    end
    check("latency", lat, 3);
    check("we_cycles", n_we, (op != 3'd7) ? 1 : 0);
    @(posedge nclk);
    #1;
    check("ready_after", int'(instr_ready), 1);
    check_regfile("regfile");
    check("flag_c", int'(flag_c), int'(mdl_c));
    check("flag_z", int'(flag_z), int'(mdl_z));
    check("result", int'(result), int'(mdl_res));
  endtask

  initial begin
    int n_ready, n_done, n_acc, n_bad;
    bit pend;

    tbl[0] = '{op: 3'd0, rd: 4'd0,  ra: 4'd3,  rb: 4'd5,  imm: 8'h00, val: 8'h08, c: 1'b0, z: 1'b0};
    tbl[1] = '{op: 3'd5, rd: 4'd1,  ra: 4'd0,  rb: 4'd0,  imm: 8'hF0, val: 8'hF0, c: 1'b0, z: 1'b0};
    tbl[2] = '{op: 3'd5, rd: 4'd2,  ra: 4'd0,  rb: 4'd0,  imm: 8'h20, val: 8'h20, c: 1'b0, z: 1'b0};
    tbl[3] = '{op: 3'd0, rd: 4'd3,  ra: 4'd1,  rb: 4'd2,  imm: 8'h00, val: 8'h10, c: 1'b1, z: 1'b0};
    tbl[4] = '{op: 3'd1, rd: 4'd4,  ra: 4'd2,  rb: 4'd1,  imm: 8'h00, val: 8'h30, c: 1'b1, z: 1'b0};
    tbl[5] = '{op: 3'd4, rd: 4'd5,  ra: 4'd6,  rb: 4'd6,  imm: 8'h00, val: 8'h00, c: 1'b0, z: 1'b1};
    tbl[6] = '{op: 3'd7, rd: 4'd11, ra: 4'd1,  rb: 4'd2,  imm: 8'h55, val: 8'h0B, c: 1'b0, z: 1'b1};
    tbl[7] = '{op: 3'd5, rd: 4'd10, ra: 4'd0,  rb: 4'd0,  imm: 8'h80, val: 8'h80, c: 1'b0, z: 1'b1};
    tbl[8] = '{op: 3'd0, rd: 4'd10, ra: 4'd10, rb: 4'd10, imm: 8'h00, val: 8'h00, c: 1'b1, z: 1'b1};

    for (int i = 0; i < 16; i++) mdl_regs[i] = 8'(i);
    mdl_res = 8'h00; mdl_c = 1'b0; mdl_z = 1'b0;

    reset = 1'b1; load_rf = 1'b1; instr_valid = 1'b0;
    instr_op = 3'd0; instr_rd = 4'd0; instr_ra = 4'd0; instr_rb = 4'd0; instr_imm = 8'h00;
    repeat (2) @(posedge nclk);
    #1 load_rf = 1'b0;
    check("rst_ready", int'(instr_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_we", int'(rf_we), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_flags", int'({flag_c, flag_z}), 0);
    @(posedge nclk);
    #1 reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      issue(tbl[i].op, tbl[i].rd, tbl[i].ra, tbl[i].rb, tbl[i].imm);
      check($sformatf("tbl%0d_val", i), int'(rf[tbl[i].rd]), int'(tbl[i].val));
      check($sformatf("tbl%0d_c", i), int'(flag_c), int'(tbl[i].c));
      check($sformatf("tbl%0d_z", i), int'(flag_z), int'(tbl[i].z));
    end

    // Back-to-back with valid held: MOV r7,r2 then ADD r8,r7,r7.
    n_ready = 0; n_done = 0; n_acc = 0; pend = 0;
    @(negedge nclk);
    instr_op = 3'd6; instr_rd = 4'd7; instr_ra = 4'd2; instr_rb = 4'd0;
    instr_valid = 1'b1;
    model_exec(3'd6, 4'd7, 4'd2, 4'd0, 8'h00);
    model_exec(3'd0, 4'd8, 4'd7, 4'd7, 8'h00);
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc > 0) @(negedge nclk);
      if (instr_ready) begin n_ready++; pend = 1; end
      if (done) n_done++;
      @(posedge nclk);
      #1;
      if (pend) begin
        n_acc++;
        if (n_acc == 1) begin
          instr_op = 3'd0; instr_rd = 4'd8; instr_ra = 4'd7; instr_rb = 4'd7;
        end else begin
          instr_valid = 1'b0;
        end
      end
      pend = 0;
    end
    check("b2b_ready_cycles", n_ready, 2);
    @(negedge nclk);
    if (done) n_done++;
    check("b2b_done_pulses", n_done, 2);
    repeat (2) @(posedge nclk);
    #1;
    check("b2b_r8", int'(rf[8]), 8'h40);
    check_regfile("b2b_regfile");

    // Reset during EXEC of ADD r9,r1,r1: write must never happen.
    @(negedge nclk);
    instr_op = 3'd0; instr_rd = 4'd9; instr_ra = 4'd1; instr_rb = 4'd1;
    instr_valid = 1'b1;
    @(posedge nclk);
    #1 instr_valid = 1'b0;
    @(posedge nclk);
    #2 reset = 1'b1;
    #1;
    check("abort_ready", int'(instr_ready), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_flags", int'({flag_c, flag_z}), 0);
    n_bad = 0;
    @(negedge nclk);
    if (rf_we || done) n_bad++;
    @(posedge nclk);
    #1 reset = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge nclk);
      if (rf_we || done) n_bad++;
    end
    check("abort_no_write", n_bad, 0);
    check("abort_r9", int'(rf[9]), 9);
    check("abort_state_idle", int'(instr_ready), 1);
    mdl_c = 1'b0; mdl_z = 1'b0; mdl_res = 8'h00;
    check_regfile("abort_regfile");

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Control unit for the calculator datapath. Accepts one instruction at a time through a valid/ready handshake.
- Sequences the 16x8 dual-read / single-write register file: drives the two read addresses, latches operands, computes the result in an internal ALU, then writes it back.
- Adds the write enable and status flags that the bare register file lacks. Sits between the instruction source (switches/ROM stepper) and the register file.

Parameters:
- DATA_W, 8, operand/result width
- ADDR_W, 4, register address width (2^ADDR_W registers)

Ports:
- nclk  in  1  clock; sequencer state updates on rising edge, register file writes on falling edge
- reset  in  1  asynchronous, active-high
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept an instruction
- instr_op  in  3  opcode
- instr_rd  in  ADDR_W  destination register
- instr_ra  in  ADDR_W  source A register
- instr_rb  in  ADDR_W  source B register
- instr_imm  in  DATA_W  immediate for LDI
- rf_addr_a  out  ADDR_W  register file read address A
- rf_addr_b  out  ADDR_W  register file read address B
- rf_addr_d  out  ADDR_W  register file write address
- rf_data_in  out  DATA_W  register file write data
- rf_we  out  1  register file write enable
- rf_out_a  in  DATA_W  register file read data A (combinational)
- rf_out_b  in  DATA_W  register file read data B (combinational)
- result  out  DATA_W  last computed result
- flag_c  out  1  carry/borrow flag
- flag_z  out  1  zero flag
- done  out  1  one-cycle pulse when an instruction retires
- busy  out  1  instruction in flight

Behaviour:
- One clock, nclk. Reset is asynchronous and active-high.
- State register, rising edge of nclk: IDLE, READ, EXEC, WRITE.
- Reset values: state=IDLE, instruction register=0, operand latches=0, result=0, flag_c=0, flag_z=0.
  - Outputs during reset: rf_we=0, done=0, busy=0, instr_ready=1.
- instr_ready = (state==IDLE). busy = !instr_ready.
- Accept when instr_valid && instr_ready at a rising edge (edge k): latch op/rd/ra/rb/imm, go to READ.
- READ: rf_addr_a=ra, rf_addr_b=rb. At edge k+1, latch rf_out_a and rf_out_b into op_a/op_b, go to EXEC.
- EXEC: ALU evaluates op_a/op_b. At edge k+2, latch result and flags, go to WRITE.
- WRITE:
  - rf_addr_d=rd, rf_data_in=result, rf_we=1 (except NOP).
  - The register file commits at the falling edge inside this cycle.
  - done=1. At edge k+3, go to IDLE.
- Outside WRITE: rf_we=0, rf_addr_d=rd latch, rf_data_in=result. rf_addr_a/b hold the latched ra/rb in all states.
- Throughput: one instruction per 4 cycles. Latency from acceptance edge to done: 3 cycles.
- No read-after-write hazard: the write completes on the falling edge before the next READ.
- Opcodes (results truncated to DATA_W):
  - 0 ADD: {c,res}=a+b.
  - 1 SUB: res=a-b, c=1 iff a<b (borrow).
  - 2 AND, 3 OR, 4 XOR: c=0.
  - 5 LDI: res=imm.
  - 6 MOV: res=a, c=0.
  - 7 NOP: no write.
- Flags:
  - ADD..XOR and MOV update flag_c and flag_z (z = res==0).
  - LDI and NOP leave both flags unchanged.
  - NOP also leaves result unchanged.
- rd==ra or rd==rb is legal. Operands are latched before the write, so the old value is used.
- instr_valid while busy: ignored, not queued. The source must hold valid until ready.
- Reset mid-operation:
  - State goes to IDLE immediately.
  - rf_we falls combinationally, so an in-flight write is aborted if reset asserts before the falling edge.
  - No done pulse for the aborted instruction.
- rf_we is decoded from the registered state only; it must be glitch-free across the falling edge.

Decomposition:
- Package calc_pkg holds:
  - opcode localparams OP_ADD..OP_NOP
  - state encodings S_IDLE..S_WRITE
  - DATA_W/ADDR_W defaults
- Sub-module calc_alu: combinational; inputs op, a, b, imm; outputs res, c, z, and upd_flags.
- calc_sequencer holds the FSM, instruction register, operand/result/flag registers and register file drive.

Test Plan:
- Register file model preloaded reg[i]=i; issue ADD rd=0, ra=3, rb=5 -> done 3 cycles after acceptance; rf_we=1, rf_addr_d=0, rf_data_in=8 only in WRITE; reg0=8, flag_c=0, flag_z=0.
- LDI r1,0xF0 then LDI r2,0x20 then ADD r3,r1,r2 -> r3=0x10, flag_c=1, flag_z=0. Then SUB r4,r2,r1 -> r4=0x30, flag_c=1 (borrow).
- XOR r5,r6,r6 -> r5=0, flag_z=1, flag_c=0. Then NOP -> rf_we stays 0 for the whole instruction, done pulses, flags unchanged.
- Hold instr_valid continuously with back-to-back MOV r7,r2 and ADD r8,r7,r7 -> instr_ready high only 1 of every 4 cycles; r8 = 2*r2 (no hazard).
- Assert reset during EXEC of ADD r9,r1,r1 -> state IDLE, rf_we never asserted, r9 unchanged (=9), flags 0, instr_ready=1 immediately.
- ADD r10,r10,r10 with r10=0x80 -> r10=0x00, flag_c=1, flag_z=1 (self-overwrite uses the old operand).
